// File: rtl/bin2gray_counter_if.sv
// -----------------------------------------------------------------------------
// bin2gray_counter_if
//
// Purpose : Bundles the control, load and status signals of bin2gray_counter
//           so the counter and its driver share one typed connection.
//
// Signals :
//   en      - advance the count by one step this cycle
//   up      - direction: 1 = increment, 0 = decrement (used only with en)
//   load    - load b_in this cycle; overrides en
//   b_in    - binary value to load
//   b       - registered binary count
//   g       - registered Gray code of b
//   tc      - registered terminal-count pulse (count wrapped on the last step)
//   step_ok - registered pulse: last step changed exactly one bit of g
//
// Modports:
//   master - the side that controls the counter (drives en/up/load/b_in)
//   slave  - the counter itself (drives b/g/tc/step_ok)
// -----------------------------------------------------------------------------
interface bin2gray_counter_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic             tc;
    logic             step_ok;

    modport master (
        output en,
        output up,
        output load,
        output b_in,
        input  b,
        input  g,
        input  tc,
        input  step_ok
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  b_in,
        output b,
        output g,
        output tc,
        output step_ok
    );

endinterface : bin2gray_counter_if

// File: rtl/bin2gray_counter.sv
// -----------------------------------------------------------------------------
// bin2gray_counter
//
// Purpose : Registered up/down binary counter that also presents its state in
//           Gray code. Supports a synchronous binary load. It produces the
//           Gray sequence consumed by the Gray-to-binary converter and feeds
//           Gray-coded pointers where only one bit may change per step.
//
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous reset, active-high
//   bus  - bin2gray_counter_if.slave
//            inputs : en, up, load, b_in
//            outputs: b, g, tc, step_ok (all registered)
//
// Priority at each rising edge: rst > load > en > hold.
// -----------------------------------------------------------------------------
module bin2gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    bin2gray_counter_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Binary to reflected-binary Gray code.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction

    // True when exactly one bit of v is set: non-zero and clearing the lowest
    // set bit leaves nothing behind.
    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] g_q;
    logic             tc_q;
    logic             step_ok_q;

    // -------------------------------------------------------------------------
    // Next-step values, used only when a step is taken
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] nb;        // next binary count
    logic [WIDTH-1:0] ng;        // Gray code of next count
    logic             wrap;      // this step crosses the all-ones/zero boundary
    logic             one_bit;   // this step flips exactly one Gray bit

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        nb      = b_q;
        wrap    = 1'b0;
        if (bus.up) begin
            nb   = b_q + 1'b1;
            wrap = (b_q == '1);
        end else begin
            nb   = b_q - 1'b1;
            wrap = (b_q == '0);
        end
        // Gray is derived from the next binary value and registered, so b and
        // g always change on the same edge and g is glitch-free at the output.
        ng      = to_gray(nb);
        // Compare against the currently registered Gray value, not one
        // recomputed from b, so a corrupted g register would be caught too.
        one_bit = is_onehot(g_q ^ ng);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and simulation matches hardware.
        if (rst) begin
            b_q       <= '0;
            g_q       <= '0;
            tc_q      <= 1'b0;
            step_ok_q <= 1'b0;
        end else if (bus.load) begin
            b_q       <= bus.b_in;
            g_q       <= to_gray(bus.b_in);
            tc_q      <= 1'b0;
            step_ok_q <= 1'b0;
        end else if (bus.en) begin
            b_q       <= nb;
            g_q       <= ng;
            tc_q      <= wrap;
            step_ok_q <= one_bit;
        end else begin
            // Count holds; the status flags are single-cycle pulses.
            tc_q      <= 1'b0;
            step_ok_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: straight from registers, no input-to-output paths
    // -------------------------------------------------------------------------
    assign bus.b       = b_q;
    assign bus.g       = g_q;
    assign bus.tc      = tc_q;
    assign bus.step_ok = step_ok_q;

endmodule : bin2gray_counter

// File: tb/tb_bin2gray_counter.sv
// -----------------------------------------------------------------------------
// tb_bin2gray_counter
//
// Self-checking bench for bin2gray_counter (WIDTH = 4). Each driven cycle
// pushes the expected outputs into a scoreboard queue; after the clock edge
// the entry is popped and compared with the DUT. A Gray-to-binary decoder in
// the bench checks the round trip g -> binary == b.
// -----------------------------------------------------------------------------
module tb_bin2gray_counter;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic         tc;
        logic         step_ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bin2gray_counter_if #(.WIDTH(W)) bus ();

    bin2gray_counter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] m_b   = '0;   // reference model binary count

    // Expected Gray sequence for 16 up-steps starting at 0.
    logic [W-1:0] up_seq [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
        4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
    };

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Gray-to-binary decoder (bench-side GB).
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] gv);
        logic [W-1:0] r;
        r[W-1] = gv[W-1];
        for (int i = W - 2; i >= 0; i--) r[i] = r[i+1] ^ gv[i];
        return r;
    endfunction

    // Drive one cycle, push expectation, then pop and compare after the edge.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic u, input logic [W-1:0] bi);
        exp_t x;
        exp_t got;
        @(negedge clk);
        rst      = r;
        bus.load = l;
        bus.en   = e;
        bus.up   = u;
        bus.b_in = bi;
        x.tc      = 1'b0;
        x.step_ok = 1'b0;
        if (r) begin
            m_b = '0;
        end else if (l) begin
            m_b = bi;
        end else if (e) begin
            x.tc      = u ? (m_b == 4'hF) : (m_b == 4'h0);
            x.step_ok = 1'b1;
            m_b       = u ? m_b + 4'd1 : m_b - 4'd1;
        end
        x.b = m_b;
        x.g = m_b ^ (m_b >> 1);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("b",       {28'd0, bus.b},        {28'd0, got.b});
        check("g",       {28'd0, bus.g},        {28'd0, got.g});
        check("tc",      {31'd0, bus.tc},       {31'd0, got.tc});
        check("step_ok", {31'd0, bus.step_ok},  {31'd0, got.step_ok});
        check("roundtrip", {28'd0, gray2bin(bus.g)}, {28'd0, got.b});
    endtask

    initial begin
        bus.en   = 1'b1;
        bus.up   = 1'b1;
        bus.load = 1'b1;
        bus.b_in = 4'hA;

        // Reset dominates en and load.
        step(1, 1, 1, 1, 4'hA);
        step(1, 1, 1, 1, 4'hA);

        // Full up sweep from 0 with constant table for the Gray sequence.
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 1, 4'h0);
            check("gseq", {28'd0, bus.g}, {28'd0, up_seq[i]});
        end
        check("wrap_tc", {31'd0, bus.tc}, 32'd1);

        // Down wrap from 0.
        step(0, 0, 1, 0, 4'h0);
        check("down_g", {28'd0, bus.g}, 32'h8);
        step(0, 0, 1, 0, 4'h0);
        check("down_g2", {28'd0, bus.g}, 32'h9);

        // Load wins over en; then hold for 3 cycles.
        step(0, 1, 1, 1, 4'hA);
        check("load_g", {28'd0, bus.g}, 32'hF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 4'h3);

        // Reset mid-count at 0110, then resume.
        step(0, 1, 0, 1, 4'h5);
        step(0, 0, 1, 1, 4'h0);
        check("pre_rst_b", {28'd0, bus.b}, 32'h6);
        step(1, 0, 1, 1, 4'h0);
        step(0, 0, 1, 1, 4'h0);
        check("resume_g", {28'd0, bus.g}, 32'h1);

        // Round-trip sweep: up to 0111, reverse, down through wrap, up again.
        step(1, 0, 0, 1, 4'h0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 4'h0);
        check("rev_b", {28'd0, bus.b}, 32'h7);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 4'h0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 1'($urandom), 4'($urandom));
        end

        check("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bin2gray_counter
